bcd_serial_adder_ctrl: RTL and testbench

BCD_SERIAL_ADDER_CTRL -- requirements
Module: bcd_serial_adder_ctrl

---
 rtl/bcd_serial_adder_ctrl_pkg.sv | 18 +
 rtl/bcd_serial_adder_ctrl_if.sv | 22 ++
 rtl/bcd_digit_add.sv | 30 +++
 rtl/bcd_serial_adder_ctrl.sv | 127 ++++++++++++
 tb/tb_bcd_serial_adder_ctrl.sv | 217 +++++++++++++++++++++
 5 files changed

// File: rtl/bcd_serial_adder_ctrl_pkg.sv
// Shared types and constants for the serial BCD adder controller.
package bcd_serial_adder_ctrl_pkg;

  localparam int unsigned DIGIT_W = 4;
  localparam int unsigned RADIX   = 10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Nines complement of one BCD digit; invalid digits map to values >9.
  function automatic logic [DIGIT_W-1:0] nines_comp(input logic [DIGIT_W-1:0] d);
    return DIGIT_W'(RADIX - 1) - d;
  endfunction

endpackage

// File: rtl/bcd_serial_adder_ctrl_if.sv
// Request/result bundle between a requester and the serial BCD adder.
interface bcd_serial_adder_ctrl_if
  import bcd_serial_adder_ctrl_pkg::*;
#(
  parameter int unsigned NDIG = 4
);
  localparam int unsigned W = DIGIT_W * NDIG;

  logic         start;
  logic         op;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;
  logic         err;

  modport master (output start, op, a, b, input busy, done, sum, cout, err);
  modport slave  (input start, op, a, b, output busy, done, sum, cout, err);

endinterface

// File: rtl/bcd_digit_add.sv
// One-digit BCD adder; an invalid input digit yields 4'hF with no carry.
module bcd_digit_add
  import bcd_serial_adder_ctrl_pkg::*;
(
  input  logic [DIGIT_W-1:0] a,
  input  logic [DIGIT_W-1:0] b,
  input  logic               cin,
  output logic [DIGIT_W-1:0] s,
  output logic               cout,
  output logic               bad
);
  localparam int unsigned TW = DIGIT_W + 1;

  logic [TW-1:0] t;

  always_comb begin
    t    = TW'(a) + TW'(b) + TW'(cin);
    bad  = (a > DIGIT_W'(RADIX - 1)) || (b > DIGIT_W'(RADIX - 1));
    s    = t[DIGIT_W-1:0];
    cout = 1'b0;
    if (bad) begin
      s    = '1;
      cout = 1'b0;
    end else if (t > TW'(RADIX - 1)) begin
      s    = DIGIT_W'(t - TW'(RADIX));
      cout = 1'b1;
    end
  end

endmodule

// File: rtl/bcd_serial_adder_ctrl.sv
// Digit-serial BCD adder controller: one digit per cycle through a shared adder.
// Define BCD_SUB_EN to enable subtraction (op=1) via nines complement.
module bcd_serial_adder_ctrl
  import bcd_serial_adder_ctrl_pkg::*;
#(
  parameter int unsigned NDIG = 4
)(
  input  logic                   CLOCK_50,
  input  logic                   resetn,
  bcd_serial_adder_ctrl_if.slave bus
);
  localparam int unsigned W  = DIGIT_W * NDIG;
  localparam int unsigned IW = (NDIG > 1) ? $clog2(NDIG) : 1;

  state_t          state_q, state_n;
  logic [IW-1:0]   idx_q, idx_n;
  logic            carry_q, carry_n;
  logic            op_q, op_n;
  logic [W-1:0]    a_q, a_n, b_q, b_n, sum_q, sum_n;
  logic            busy_q, busy_n, done_q, done_n;
  logic            cout_q, cout_n, err_q, err_n;

  logic                op_in_c;
  logic [DIGIT_W-1:0]  da_c, db_raw_c, db_c, ds_c;
  logic                dc_c, dbad_c;

`ifdef BCD_SUB_EN
  assign op_in_c = bus.op;
  assign db_c    = op_q ? nines_comp(db_raw_c) : db_raw_c;
`else
  logic unused_op;
  assign unused_op = bus.op;
  assign op_in_c   = 1'b0;
  assign db_c      = db_raw_c;
`endif

  assign da_c     = a_q[idx_q*DIGIT_W +: DIGIT_W];
  assign db_raw_c = b_q[idx_q*DIGIT_W +: DIGIT_W];

  bcd_digit_add u_digit (
    .a    (da_c),
    .b    (db_c),
    .cin  (carry_q),
    .s    (ds_c),
    .cout (dc_c),
    .bad  (dbad_c)
  );

  always_comb begin
    state_n = state_q;
    idx_n   = idx_q;
    carry_n = carry_q;
    op_n    = op_q;
    a_n     = a_q;
    b_n     = b_q;
    sum_n   = sum_q;
    cout_n  = cout_q;
    err_n   = err_q;
    done_n  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          a_n     = bus.a;
          b_n     = bus.b;
          op_n    = op_in_c;
          carry_n = op_in_c;
          idx_n   = '0;
          sum_n   = '0;
          cout_n  = 1'b0;
          err_n   = 1'b0;
          state_n = RUN;
        end
      end
      RUN: begin
        sum_n[idx_q*DIGIT_W +: DIGIT_W] = ds_c;
        carry_n = dc_c;
        err_n   = err_q | dbad_c;
        idx_n   = idx_q + IW'(1);
        if (idx_q == IW'(NDIG - 1)) begin
          // Borrow is the inverse of the final decimal carry when subtracting.
          cout_n  = op_q ? ~dc_c : dc_c;
          done_n  = 1'b1;
          idx_n   = '0;
          state_n = DONE;
        end
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
    busy_n = (state_n != IDLE);
  end

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      op_q    <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      cout_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_n;
      idx_q   <= idx_n;
      carry_q <= carry_n;
      op_q    <= op_n;
      a_q     <= a_n;
      b_q     <= b_n;
      sum_q   <= sum_n;
      busy_q  <= busy_n;
      done_q  <= done_n;
      cout_q  <= cout_n;
      err_q   <= err_n;
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;
  assign bus.err  = err_q;

endmodule

// File: tb/tb_bcd_serial_adder_ctrl.sv
// Scoreboard bench for bcd_serial_adder_ctrl (NDIG=4); honours BCD_SUB_EN.
module tb_bcd_serial_adder_ctrl;
  localparam int unsigned NDIG = 4;
  localparam int unsigned W    = 4 * NDIG;
`ifdef BCD_SUB_EN
  localparam bit SUB_EN = 1'b1;
`else
  localparam bit SUB_EN = 1'b0;
`endif

  typedef struct {
    logic [W-1:0] sum;
    logic         cout;
    logic         err;
    int unsigned  cyc;
  } exp_t;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  int unsigned cyc   = 0;
  int          n_chk = 0;
  int          n_pass = 0;
  exp_t        sb[$];

  bcd_serial_adder_ctrl_if #(.NDIG(NDIG)) bus ();

  bcd_serial_adder_ctrl #(.NDIG(NDIG)) dut (
    .CLOCK_50 (clk),
    .resetn   (rst_n),
    .bus      (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Reference: digit-wise decimal arithmetic; subtraction via nines complement + 1.
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic op);
    exp_t e;
    logic sub, c;
    logic [3:0] da, db;
    int t;
    sub   = SUB_EN & op;
    c     = sub;
    e.sum = '0;
    e.err = 1'b0;
    e.cyc = 0;
    for (int i = 0; i < NDIG; i++) begin
      da = a[4*i +: 4];
      db = b[4*i +: 4];
      if (da > 4'd9 || db > 4'd9) begin
        e.err = 1'b1;
        e.sum[4*i +: 4] = 4'hF;
        c = 1'b0;
      end else begin
        t = int'(da) + (sub ? 9 - int'(db) : int'(db)) + (c ? 1 : 0);
        if (t > 9) begin
          e.sum[4*i +: 4] = 4'(t - 10);
          c = 1'b1;
        end else begin
          e.sum[4*i +: 4] = 4'(t);
          c = 1'b0;
        end
      end
    end
    e.cout = sub ? ~c : c;
    return e;
  endfunction

  // Result monitor: every done pulse must match the oldest expected result and latency.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && bus.done) begin
      if (sb.size() == 0) begin
        check("spurious_done", 32'(bus.done), 32'd0);
      end else begin
        e = sb.pop_front();
        check("sum",     32'(bus.sum),  32'(e.sum));
        check("cout",    32'(bus.cout), 32'(e.cout));
        check("err",     32'(bus.err),  32'(e.err));
        check("latency", cyc,           e.cyc);
      end
    end
  end

  task automatic wait_idle();
    bit ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      if (sb.size() == 0 && !bus.busy) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check("timeout", 32'd0, 32'd1);
  endtask

  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic op);
    exp_t e;
    wait_idle();
    bus.a = a; bus.b = b; bus.op = op; bus.start = 1'b1;
    e = model(a, b, op);
    e.cyc = cyc + NDIG + 1;
    sb.push_back(e);
    @(posedge clk); #1;
    bus.start = 1'b0;
    check("busy_run", 32'(bus.busy), 32'd1);
  endtask

  initial begin
    exp_t e;
    bus.start = 1'b0; bus.op = 1'b0; bus.a = '0; bus.b = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_sum",  32'(bus.sum),  32'd0);
    check("rst_cout", 32'(bus.cout), 32'd0);
    check("rst_err",  32'(bus.err),  32'd0);
    rst_n = 1'b1;

    do_op(16'h1234, 16'h5678, 1'b0);
    wait_idle();
    check("v1234_sum",  32'(bus.sum),  32'h6912);
    check("v1234_cout", 32'(bus.cout), 32'd0);

    do_op(16'h9999, 16'h0001, 1'b0);
    wait_idle();
    check("v9999_sum",  32'(bus.sum),  32'h0000);
    check("v9999_cout", 32'(bus.cout), 32'd1);

    do_op(16'h00A5, 16'h0001, 1'b0);
    wait_idle();
    check("bad_sum", 32'(bus.sum), 32'h00F6);
    check("bad_err", 32'(bus.err), 32'd1);

    // Start re-pulsed during RUN with different operands must be ignored.
    do_op(16'h0042, 16'h0057, 1'b0);
    @(posedge clk); #1;
    bus.a = 16'h9999; bus.b = 16'h9999; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    wait_idle();
    repeat (3) @(posedge clk);
    #1;
    check("hold_sum",  32'(bus.sum),  32'h0099);
    check("hold_cout", 32'(bus.cout), 32'd0);

    // Asynchronous reset in the third RUN cycle aborts with no done pulse.
    do_op(16'h1234, 16'h5678, 1'b0);
    @(posedge clk);
    @(posedge clk); #2;
    rst_n = 1'b0;
    sb.delete();
    #1;
    check("abort_busy", 32'(bus.busy), 32'd0);
    check("abort_sum",  32'(bus.sum),  32'd0);
    check("abort_done", 32'(bus.done), 32'd0);
    @(posedge clk); #3;
    rst_n = 1'b1;
    repeat (6) @(posedge clk);
    do_op(16'h0808, 16'h0203, 1'b0);
    wait_idle();
    check("post_rst_sum", 32'(bus.sum), 32'h1011);

    // Start held high: two operations separated by one IDLE cycle.
    bus.a = 16'h4321; bus.b = 16'h1111; bus.op = 1'b0; bus.start = 1'b1;
    e = model(16'h4321, 16'h1111, 1'b0);
    e.cyc = cyc + NDIG + 1;
    sb.push_back(e);
    e.cyc = cyc + 2 * NDIG + 3;
    sb.push_back(e);
    repeat (6) @(posedge clk);
    #1;
    check("b2b_gap", 32'(bus.busy), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    bus.start = 1'b0;
    wait_idle();

`ifdef BCD_SUB_EN
    do_op(16'h0500, 16'h0123, 1'b1);
    wait_idle();
    check("sub_pos_sum",  32'(bus.sum),  32'h0377);
    check("sub_pos_cout", 32'(bus.cout), 32'd0);
    do_op(16'h0123, 16'h0500, 1'b1);
    wait_idle();
    check("sub_neg_sum",  32'(bus.sum),  32'h9623);
    check("sub_neg_cout", 32'(bus.cout), 32'd1);
`else
    do_op(16'h0500, 16'h0123, 1'b1);
    wait_idle();
    check("op_ignored_sum",  32'(bus.sum),  32'h0623);
    check("op_ignored_cout", 32'(bus.cout), 32'd0);
`endif

    for (int n = 0; n < 12; n++) begin
      logic [W-1:0] ra, rb;
      for (int i = 0; i < NDIG; i++) begin
        ra[4*i +: 4] = ($urandom_range(0, 15) == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9));
        rb[4*i +: 4] = ($urandom_range(0, 15) == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9));
      end
      do_op(ra, rb, 1'($urandom_range(0, 1)));
    end
    wait_idle();
    repeat (3) @(posedge clk);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
